// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package sevseg_pkg;

  typedef logic [3:0] hex_t;

  typedef enum logic {BLANK, ON} scan_state_t;

  // Phase counter width: enough bits to count 0..max(dwell,blank)-1, never zero.
  function automatic int timer_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable up-counter that flags the cycle on which it sits at its limit.
module phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Scans NUM_DIGITS hex digits onto one shared decoder, blanking all anodes before
// each digit switch and committing new digit values only at frame boundaries.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 40000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic                    disp_en,
  output hex_t                    hex_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_start
);

  localparam int CW = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  hex_t [NUM_DIGITS-1:0] active_q, active_d, shadow_q;
  logic pending_q;

  logic [CW-1:0] limit;
  logic tc;
  logic accept, wrap, commit;

  hex_t hex_d;
  logic [NUM_DIGITS-1:0] anode_d;
  logic frame_d;

  assign limit = (state_q == ON) ? DWELL_LAST : BLANK_LAST;

  // The timer restarts from zero on every terminal count, i.e. at each phase change.
  phase_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tc),
    .load_val ('0),
    .limit    (limit),
    .tc       (tc)
  );

  assign accept = upd_valid & upd_ready;
  assign wrap   = tc && (state_q == ON) && (idx_q == LAST_IDX);
  assign commit = wrap && pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      active_q    <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      upd_ready   <= 1'b1;
      hex_out     <= '0;
      anode_n     <= '1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      hex_out     <= hex_d;
      anode_n     <= anode_d;
      frame_start <= frame_d;
      if (accept) begin
        shadow_q  <= digits_in;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
      // Ready drops with the accept and only returns the cycle after a commit.
      if (accept || commit) begin
        upd_ready <= 1'b0;
      end else begin
        upd_ready <= ~pending_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = commit ? shadow_q : active_q;
    if (tc) begin
      if (state_q == BLANK) begin
        state_d = ON;
      end else begin
        state_d = BLANK;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end
    end
  end

  // Outputs are computed from the next state so the registers line up with the phase.
  always_comb begin
    hex_d   = hex_out;
    anode_d = '1;
    frame_d = wrap;
    if (tc && (state_q == ON)) begin
      hex_d = active_d[idx_d];
    end
    if ((state_d == ON) && disp_en) begin
      anode_d[idx_d] = 1'b0;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboard bench for sevseg_scan_ctrl with NUM_DIGITS=2, DWELL=4, BLANK=2.
module tb_sevseg_scan_ctrl;

  localparam int ND = 2;
  localparam int DW = 4;
  localparam int BL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] digits_in = 8'h00;
  logic       upd_valid = 1'b0;
  logic       disp_en = 1'b1;
  logic       upd_ready;
  logic [3:0] hex_out;
  logic [1:0] anode_n;
  logic       frame_start;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] anode;
    logic [3:0] hex;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  sevseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .disp_en    (disp_en),
    .hex_out    (hex_out),
    .anode_n    (anode_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Cycle index relative to the last clock edge that saw reset high.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic checkOutput(input string name, input int c, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, c, actual, required);
    end
  endtask

  task automatic pushExp(input int c, input logic [1:0] a, input logic [3:0] h,
                         input logic f, input logic r);
    exp_t e;
    e.cyc = c; e.anode = a; e.hex = h; e.fs = f; e.rdy = r;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic en);
    upd_valid = v;
    digits_in = d;
    disp_en   = en;
  endtask

  task automatic waitCycle(input int n);
    int g = 0;
    while (cyc != n && g < 300) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (cyc != n) checkOutput("wait_timeout", n, cyc, n);
  endtask

  // Scoreboard monitor: pops the expectation tagged with the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          checkOutput("entry_missed", e.cyc, 1, 0);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          checkOutput("anode_n", cyc, anode_n, e.anode);
          checkOutput("hex_out", cyc, hex_out, e.hex);
          checkOutput("frame_start", cyc, frame_start, e.fs);
          checkOutput("upd_ready", cyc, upd_ready, e.rdy);
        end
      end
    end
  end

  // Anti-ghost watcher: anodes dark when hex changes and for BLANK cycles after.
  initial begin
    logic [3:0] prev;
    int since;
    prev  = 4'h0;
    since = BL;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hex_out !== prev) since = 0;
        else if (since < BL) since++;
        if (since < BL) checkOutput("ghost_blank", cyc, anode_n, 2'b11);
        checkOutput("one_anode", cyc, ($countones(~anode_n) <= 1) ? 1 : 0, 1);
        prev = hex_out;
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    // Reset/startup and single update of A5.
    pushExp(0, 2'b11, 4'h0, 1'b0, 1'b1);
    pushExp(1, 2'b11, 4'h0, 1'b0, 1'b1);
    pushExp(2, 2'b10, 4'h0, 1'b0, 1'b1);
    pushExp(3, 2'b10, 4'h0, 1'b0, 1'b1);
    pushExp(4, 2'b10, 4'h0, 1'b0, 1'b0);
    pushExp(5, 2'b10, 4'h0, 1'b0, 1'b0);
    pushExp(6, 2'b11, 4'h0, 1'b0, 1'b0);
    pushExp(7, 2'b11, 4'h0, 1'b0, 1'b0);
    pushExp(8, 2'b01, 4'h0, 1'b0, 1'b0);
    pushExp(11, 2'b01, 4'h0, 1'b0, 1'b0);
    pushExp(12, 2'b11, 4'h5, 1'b1, 1'b0);
    pushExp(13, 2'b11, 4'h5, 1'b0, 1'b1);
    pushExp(14, 2'b10, 4'h5, 1'b0, 1'b1);
    pushExp(18, 2'b11, 4'hA, 1'b0, 1'b1);
    pushExp(20, 2'b01, 4'hA, 1'b0, 1'b1);
    pushExp(24, 2'b11, 4'h5, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    waitCycle(3);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    waitCycle(4);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Back-pressure: 12 accepted, 34 held until the cycle after the 12 commit.
    pushExp(26, 2'b10, 4'h5, 1'b0, 1'b0);
    pushExp(30, 2'b11, 4'hA, 1'b0, 1'b0);
    pushExp(35, 2'b01, 4'hA, 1'b0, 1'b0);
    pushExp(36, 2'b11, 4'h2, 1'b1, 1'b0);
    pushExp(37, 2'b11, 4'h2, 1'b0, 1'b1);
    pushExp(38, 2'b10, 4'h2, 1'b0, 1'b0);
    pushExp(42, 2'b11, 4'h1, 1'b0, 1'b0);
    pushExp(48, 2'b11, 4'h4, 1'b1, 1'b0);
    pushExp(49, 2'b11, 4'h4, 1'b0, 1'b1);
    pushExp(54, 2'b11, 4'h3, 1'b0, 1'b1);
    pushExp(56, 2'b01, 4'h3, 1'b0, 1'b1);
    waitCycle(25);
    applyStimulus(1'b1, 8'h12, 1'b1);
    waitCycle(26);
    applyStimulus(1'b1, 8'h34, 1'b1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!upd_ready && g < 30);
    checkOutput("bp_accept_cycle", cyc, cyc, 37);
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 8'h00, 1'b1);

    // disp_en dropped mid-ON of digit 0, restored mid-ON of digit 1.
    pushExp(62, 2'b10, 4'h4, 1'b0, 1'b1);
    pushExp(63, 2'b10, 4'h4, 1'b0, 1'b1);
    pushExp(64, 2'b11, 4'h4, 1'b0, 1'b1);
    pushExp(66, 2'b11, 4'h3, 1'b0, 1'b1);
    pushExp(68, 2'b11, 4'h3, 1'b0, 1'b1);
    pushExp(69, 2'b11, 4'h3, 1'b0, 1'b1);
    pushExp(70, 2'b01, 4'h3, 1'b0, 1'b1);
    pushExp(72, 2'b11, 4'h4, 1'b1, 1'b1);
    waitCycle(63);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycle(69);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Update 77 left pending, then reset during ON of digit 1.
    pushExp(74, 2'b10, 4'h4, 1'b0, 1'b0);
    pushExp(78, 2'b11, 4'h3, 1'b0, 1'b0);
    pushExp(80, 2'b01, 4'h3, 1'b0, 1'b0);
    waitCycle(73);
    applyStimulus(1'b1, 8'h77, 1'b1);
    waitCycle(74);
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitCycle(81);
    reset = 1'b1;
    pushExp(0, 2'b11, 4'h0, 1'b0, 1'b1);
    pushExp(2, 2'b10, 4'h0, 1'b0, 1'b1);
    pushExp(6, 2'b11, 4'h0, 1'b0, 1'b1);
    pushExp(8, 2'b01, 4'h0, 1'b0, 1'b1);
    pushExp(12, 2'b11, 4'h0, 1'b1, 1'b1);
    pushExp(18, 2'b11, 4'h0, 1'b0, 1'b1);
    pushExp(20, 2'b01, 4'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    waitCycle(22);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("entry_unconsumed", e.cyc, 1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
